// File: rtl/range_sink_if.sv
// Sample stream between a producer and range_sink: valid/ready handshake plus data.
interface range_sink_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/range_sink.sv
// Windowed range checker: tracks min/max of WIN accepted samples and counts out-of-bound ones.
// Optional RANGE_SINK_STICKY_EN adds a viol_seen flag that survives windows until reset.
module range_sink #(
    parameter int W   = 8,
    parameter int WIN = 16,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    range_sink_if.slave   stream,
    output logic [W-1:0]  min_o,
    output logic [W-1:0]  max_o,
    output logic [CW-1:0] viol_cnt,
    output logic          done,
`ifdef RANGE_SINK_STICKY_EN
    output logic          viol_seen,
`endif
    output logic          err
);

    localparam int NW = 8;
    localparam logic [NW-1:0] LAST = NW'(WIN - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  lo_q;
    logic [W-1:0]  hi_q;
    logic [NW-1:0] cnt;
    logic          open;
    logic          bad;
    logic          xfer;
    logic          last;
    logic          out_of_range;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        open         = start && (state != RUN);
        bad          = (lo > hi);
        xfer         = stream.in_valid && (state == RUN);
        last         = xfer && (cnt == LAST);
        out_of_range = (stream.in_data < lo_q) || (stream.in_data > hi_q);
        state_nxt    = state;
        case (state)
            IDLE, HOLD: if (open) state_nxt = bad ? IDLE : RUN;
            RUN:        if (last) state_nxt = HOLD;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign stream.in_ready = (state == RUN);

    // Window statistics; a start in IDLE/HOLD reinitialises them even when the bounds are rejected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q     <= '0;
            hi_q     <= '0;
            cnt      <= '0;
            min_o    <= '1;
            max_o    <= '0;
            viol_cnt <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (open) begin
                lo_q     <= lo;
                hi_q     <= hi;
                cnt      <= '0;
                min_o    <= '1;
                max_o    <= '0;
                viol_cnt <= '0;
                err      <= bad;
            end else if (xfer) begin
                cnt <= cnt + 1'b1;
                if (stream.in_data < min_o) min_o <= stream.in_data;
                if (stream.in_data > max_o) max_o <= stream.in_data;
                if (out_of_range) viol_cnt <= sat_inc(viol_cnt);
                if (last) done <= 1'b1;
            end
        end
    end

`ifdef RANGE_SINK_STICKY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       viol_seen <= 1'b0;
        else if (xfer && out_of_range) viol_seen <= 1'b1;
    end
`endif

endmodule
